// File: rtl/sr_drive_pkg.sv
// rtl/sr_drive_pkg.sv - shared types and defaults for the SR latch drive controller
//
// Holds the FSM state enum, the pulse/holdoff counter width and the default
// values of the DEB_CYCLES / PULSE_CYCLES parameters.
package sr_drive_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        RST_PULSE = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    localparam int CNT_W            = 4;
    localparam int DEB_CYCLES_DEF   = 4;
    localparam int PULSE_CYCLES_DEF = 2;

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - button synchronizer, debouncer and rising-edge request
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button, active-high
//   rise       : registered one-cycle pulse on each debounced rising edge
//
// The debounced level toggles on the edge where the synchronized input has
// differed from it for DEB_CYCLES consecutive samples. A sample that matches
// the level again clears the run count.
module sr_debounce
    import sr_drive_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic       sync_1;
    logic       sync_2;
    logic       level;
    logic       level_d;
    logic [7:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            run_cnt <= 8'd0;
            rise    <= 1'b0;
        end else begin
            sync_1  <= btn;
            sync_2  <= sync_1;
            level_d <= level;
            // Registered edge detect: adds the cycle that places the first
            // S/R drive DEB_CYCLES+3 edges after the raw input is sampled.
            rise    <= level & ~level_d;
            if (sync_2 != level) begin
                if (run_cnt == DEB_LAST) begin
                    level   <= sync_2;
                    run_cnt <= 8'd0;
                end else begin
                    run_cnt <= run_cnt + 8'd1;
                end
            end else begin
                run_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/sr_drive_ctrl.sv
// rtl/sr_drive_ctrl.sv - debounced set/reset buttons to safe SR latch pulses
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   BTN_SET, BTN_RST : raw asynchronous buttons, active-high
//   S, R             : registered latch drives, never high together
//   BUSY             : high in SET_PULSE, RST_PULSE and HOLDOFF
//   CONFLICT         : one-cycle flag for simultaneous set/reset requests
//   Q, FB_ERR        : only with SR_DRIVE_FEEDBACK_EN; latch output readback
//                      and a one-cycle error flag on the last HOLDOFF cycle
//
// Optional feature macro: SR_DRIVE_FEEDBACK_EN
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int PULSE_CYCLES = PULSE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic BTN_SET,
    input  logic BTN_RST,
`ifdef SR_DRIVE_FEEDBACK_EN
    input  logic Q,
    output logic FB_ERR,
`endif
    output logic S,
    output logic R,
    output logic BUSY,
    output logic CONFLICT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

    logic             set_req;
    logic             rst_req;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (BTN_SET),
        .rise  (set_req)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (BTN_RST),
        .rise  (rst_req)
    );

    // Requests are only looked at in IDLE, so anything arriving during a
    // pulse or holdoff is simply lost rather than queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            BUSY     <= 1'b0;
            CONFLICT <= 1'b0;
        end else begin
            CONFLICT <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (set_req && rst_req) begin
                        CONFLICT <= 1'b1;
                    end else if (set_req) begin
                        state <= SET_PULSE;
                        S     <= 1'b1;
                        BUSY  <= 1'b1;
                    end else if (rst_req) begin
                        state <= RST_PULSE;
                        R     <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end
                SET_PULSE, RST_PULSE: begin
                    if (cnt == CNT_LAST) begin
                        state <= HOLDOFF;
                        cnt   <= '0;
                        S     <= 1'b0;
                        R     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    S     <= 1'b0;
                    R     <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_DRIVE_FEEDBACK_EN
    logic q_sync_1;
    logic q_sync_2;
    logic was_set;
    logic last_hold_next;

    // True when the coming edge enters the final HOLDOFF cycle; with a
    // single-cycle holdoff that is the edge leaving the pulse state.
    always_comb begin
        last_hold_next = 1'b0;
        if (PULSE_CYCLES == 1) begin
            last_hold_next = (state == SET_PULSE || state == RST_PULSE);
        end else begin
            last_hold_next = (state == HOLDOFF) && (cnt == CNT_W'(PULSE_CYCLES - 2));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync_1 <= 1'b0;
            q_sync_2 <= 1'b0;
            was_set  <= 1'b0;
            FB_ERR   <= 1'b0;
        end else begin
            q_sync_1 <= Q;
            q_sync_2 <= q_sync_1;
            if (state == IDLE && set_req && !rst_req) begin
                was_set <= 1'b1;
            end else if (state == IDLE && rst_req && !set_req) begin
                was_set <= 1'b0;
            end
            FB_ERR <= last_hold_next && (q_sync_2 != was_set);
        end
    end
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb/tb_sr_drive_ctrl.sv - directed self-checking bench for sr_drive_ctrl
module tb_sr_drive_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_set = 1'b0;
    logic btn_rst = 1'b0;
    logic s_o;
    logic r_o;
    logic busy_o;
    logic conflict_o;
`ifdef SR_DRIVE_FEEDBACK_EN
    logic q_i = 1'b0;
    logic fb_err_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_drive_ctrl #(.DEB_CYCLES(4), .PULSE_CYCLES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .BTN_SET  (btn_set),
        .BTN_RST  (btn_rst),
`ifdef SR_DRIVE_FEEDBACK_EN
        .Q        (q_i),
        .FB_ERR   (fb_err_o),
`endif
        .S        (s_o),
        .R        (r_o),
        .BUSY     (busy_o),
        .CONFLICT (conflict_o)
    );

    task automatic check(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_s", i, s_o, 1'b0);
            check("idle_r", i, r_o, 1'b0);
        end
    endtask

    initial begin
        // Reset state, observed while rst_n is held low.
        #2;
        check("rst_s", 0, s_o, 1'b0);
        check("rst_r", 0, r_o, 1'b0);
        check("rst_busy", 0, busy_o, 1'b0);
        check("rst_conflict", 0, conflict_o, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        idle_wait(3);

        // Single set pulse: S on edges 7-8, holdoff 9-10, idle from 11.
        btn_set = 1'b1;
        for (int e = 0; e < 15; e++) begin
            tick();
            check("set_s", e, s_o, (e == 7 || e == 8));
            check("set_busy", e, busy_o, (e >= 7 && e <= 10));
            check("set_r", e, r_o, 1'b0);
        end
        // Held button gives no second request; falling edge is ignored.
        idle_wait(20);
        btn_set = 1'b0;
        idle_wait(15);

        // Bouncing reset button never settles long enough.
        for (int i = 0; i < 20; i++) begin
            btn_rst = ((i / 2) % 2 == 0);
            tick();
            check("bounce_r", i, r_o, 1'b0);
        end
        btn_rst = 1'b0;
        idle_wait(15);

        // Simultaneous requests: CONFLICT at edge 7 only, no drive.
        btn_set = 1'b1;
        btn_rst = 1'b1;
        for (int e = 0; e < 15; e++) begin
            tick();
            check("conf_flag", e, conflict_o, (e == 7));
            check("conf_s", e, s_o, 1'b0);
            check("conf_r", e, r_o, 1'b0);
            check("conf_busy", e, busy_o, 1'b0);
        end
        btn_set = 1'b0;
        btn_rst = 1'b0;
        idle_wait(15);

        // Reset request one clock after set: dropped during SET_PULSE.
        btn_set = 1'b1;
        tick();
        check("drop_s", 0, s_o, 1'b0);
        btn_rst = 1'b1;
        for (int e = 1; e < 20; e++) begin
            tick();
            check("drop_s", e, s_o, (e == 7 || e == 8));
            check("drop_r", e, r_o, 1'b0);
            check("drop_busy", e, busy_o, (e >= 7 && e <= 10));
        end
        btn_set = 1'b0;
        btn_rst = 1'b0;
        idle_wait(15);

        // Reset dropped during the first S cycle clears S without a clock.
        btn_set = 1'b1;
        for (int e = 0; e < 8; e++) tick();
        check("midrst_pre_s", 7, s_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_s", 0, s_o, 1'b0);
        check("midrst_busy", 0, busy_o, 1'b0);
        btn_set = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_s", i, s_o, 1'b0);
            check("post_rst_busy", i, busy_o, 1'b0);
        end

        // Button already high when reset releases: one pulse, normal latency.
        rst_n = 1'b0;
        btn_set = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 13; e++) begin
            tick();
            check("rel_s", e, s_o, (e == 7 || e == 8));
            check("rel_r", e, r_o, 1'b0);
        end
        idle_wait(20);
        btn_set = 1'b0;
        idle_wait(15);

        // Reset-side pulse mirrors the set side.
        btn_rst = 1'b1;
        for (int e = 0; e < 13; e++) begin
            tick();
            check("rpulse_r", e, r_o, (e == 7 || e == 8));
            check("rpulse_busy", e, busy_o, (e >= 7 && e <= 10));
            check("rpulse_s", e, s_o, 1'b0);
        end
        btn_rst = 1'b0;
        idle_wait(15);

`ifdef SR_DRIVE_FEEDBACK_EN
        // Q stuck low after a set pulse flags FB_ERR at edge 10 only.
        q_i = 1'b0;
        btn_set = 1'b1;
        for (int e = 0; e < 14; e++) begin
            tick();
            check("fb_err", e, fb_err_o, (e == 10));
        end
        btn_set = 1'b0;
        idle_wait(15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable synchronized samples needed to accept a button level (range 2..255).
REQ-002 Parameter PULSE_CYCLES, default 2: width of each S/R pulse, and of the following holdoff, in clocks (range 1..15).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 BTN_SET  input  1  raw asynchronous set button, active-high.
REQ-006 BTN_RST  input  1  raw asynchronous reset button, active-high.
REQ-007 S  output  1  registered set drive to the downstream SR latch.
REQ-008 R  output  1  registered reset drive to the downstream SR latch.
REQ-009 BUSY  output  1  high while in SET_PULSE, RST_PULSE or HOLDOFF.
REQ-010 CONFLICT  output  1  one-cycle flag: set and reset edges accepted in the same cycle.

Function
REQ-011 Each button passes through a 2-flop synchronizer, then a debouncer; the debounced level toggles on the edge where the synchronized input has differed from it for DEB_CYCLES consecutive samples; a differing-then-matching sample clears the count.
REQ-012 A rising edge of a debounced level is a request; falling edges are ignored.
REQ-013 Latency: raw input rises and stays high from sampling edge k -> S (or R) high from edge k+DEB_CYCLES+3.
REQ-014 FSM states IDLE, SET_PULSE, RST_PULSE, HOLDOFF; IDLE + set request only -> SET_PULSE; IDLE + reset request only -> RST_PULSE.
REQ-015 SET_PULSE: S=1, R=0 for exactly PULSE_CYCLES clocks, then HOLDOFF; RST_PULSE symmetric with R=1, S=0.
REQ-016 HOLDOFF: S=R=0 for exactly PULSE_CYCLES clocks, then IDLE.
REQ-017 S and R SHALL never be 1 in the same cycle, under any input sequence.
REQ-018 Set and reset requests in the same IDLE cycle: state stays IDLE, S=R=0, CONFLICT=1 for that one cycle.
REQ-019 Requests arriving in any state other than IDLE are dropped, not queued.
REQ-020 Button held high generates exactly one request; a new request needs a debounced low then high.
REQ-021 Pulse/holdoff counter is 4 bits, counts up from 0, compares with PULSE_CYCLES-1; no wrap in legal range.

Reset
REQ-022 rst_n low: S=0, R=0, BUSY=0, CONFLICT=0, state IDLE, counters 0, synchronizers and debounced levels 0, immediately without clock.
REQ-023 Reset asserted mid-pulse: S/R drop to 0 asynchronously; no pulse resumes after release.
REQ-024 A button already high at reset release produces one request after the REQ-013 latency.

Configuration
REQ-025 Macro SR_DRIVE_FEEDBACK_EN defined: extra input Q (latch output, synchronized by 2 flops) and output FB_ERR; on the last HOLDOFF cycle FB_ERR pulses one cycle if synchronized Q != 1 after SET_PULSE or != 0 after RST_PULSE.
REQ-026 Macro undefined: Q and FB_ERR ports absent, no feedback logic; all other behaviour identical.

Structure
REQ-027 Package sr_drive_pkg holds the state enum (IDLE, SET_PULSE, RST_PULSE, HOLDOFF), the counter width constant (4) and the parameter defaults.
REQ-028 Sub-module sr_debounce (synchronizer + debounce counter + rising-edge output), instantiated twice.
REQ-029 S, R, BUSY, CONFLICT driven directly from flops, with no combinational path from inputs.

Verification (DEB_CYCLES=4, PULSE_CYCLES=2)
REQ-030 BTN_SET rises at edge 0 and is held -> S=1 at edges 7-8, S=0 with BUSY=1 at edges 9-10, BUSY=0 from edge 11; R stays 0.
REQ-031 BTN_RST toggling every 2 clocks for 20 clocks, then low -> R never asserts.
REQ-032 BTN_SET and BTN_RST rise at the same edge -> CONFLICT=1 for one cycle at edge 7; S and R stay 0.
REQ-033 BTN_SET held, then BTN_RST rises 1 clock later -> only the S pulse occurs (the reset request falls in SET_PULSE and is dropped); there is no R pulse.
REQ-034 rst_n drops during the first S=1 cycle -> S=0 before the next edge; no further pulse while BTN_SET is held until a debounced low then high.
REQ-035 SR_DRIVE_FEEDBACK_EN defined, Q tied 0, set pulse issued -> FB_ERR=1 for one cycle at edge 10.
